// File: rtl/ccip_txn_tracker.sv
// ----------------------------------------------------------------------------
// ccip_txn_tracker
// Passive CCI-P transaction tracker. It observes AFU-side request/response
// traffic, matches reads and writes against their responses by mdata tag,
// keeps outstanding and cumulative counts, and flags protocol violations
// (duplicate tag, orphan response, response timeout).
//
// Ports:
//   clk, SoftReset         clock, synchronous active-high reset
//   C0Tx*                  read request (valid, mdata, length 0..3 = 1..4 CL)
//   C1Tx*                  write / WrFence request (valid, is-fence, mdata)
//   C0Rx*                  read response (valid, mdata), one per CL
//   C1Rx*                  write / WrFenceRsp response (valid, is-fence, mdata)
//   rd/wr_outstanding      number of valid read / write table entries
//   fence_outstanding      fences issued but not yet responded
//   *_total                saturating cumulative request/response counts
//   err_dup_tag, err_orphan_rsp, err_timeout   one-cycle error pulses
//   err_tag                tag of the most recent error, held
// ----------------------------------------------------------------------------
module ccip_txn_tracker #(
    parameter int TAG_WIDTH      = 6,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 SoftReset,
    input  logic                 C0TxRdValid,
    input  logic [15:0]          C0TxMdata,
    input  logic [1:0]           C0TxLen,
    input  logic                 C1TxWrValid,
    input  logic                 C1TxIsFence,
    input  logic [15:0]          C1TxMdata,
    input  logic                 C0RxRdValid,
    input  logic [15:0]          C0RxMdata,
    input  logic                 C1RxWrValid,
    input  logic                 C1RxIsFence,
    input  logic [15:0]          C1RxMdata,
    output logic [TAG_WIDTH:0]   rd_outstanding,
    output logic [TAG_WIDTH:0]   wr_outstanding,
    output logic [7:0]           fence_outstanding,
    output logic [CNT_WIDTH-1:0] rd_req_total,
    output logic [CNT_WIDTH-1:0] wr_req_total,
    output logic [CNT_WIDTH-1:0] rd_rsp_total,
    output logic [CNT_WIDTH-1:0] wr_rsp_total,
    output logic                 err_dup_tag,
    output logic                 err_orphan_rsp,
    output logic                 err_timeout,
    output logic [TAG_WIDTH-1:0] err_tag
);

    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

    // Saturating increment for cumulative counters
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    // Tag tables
    logic                 rd_valid_r [DEPTH];
    logic [2:0]           rd_rem_r   [DEPTH];
    logic [CNT_WIDTH-1:0] rd_time_r  [DEPTH];
    logic                 rd_rep_r   [DEPTH];
    logic                 wr_valid_r [DEPTH];
    logic [CNT_WIDTH-1:0] wr_time_r  [DEPTH];
    logic                 wr_rep_r   [DEPTH];

    logic [CNT_WIDTH-1:0] timer_r;
    logic [TAG_WIDTH-1:0] scan_ptr_r;

    // Decoded per-cycle events
    logic [TAG_WIDTH-1:0] rd_req_tag_s, rd_rsp_tag_s, wr_req_tag_s, wr_rsp_tag_s;
    logic wr_req_s, wr_rsp_s, fence_req_s, fence_rsp_s;
    logic rd_rsp_hit_s, rd_rsp_done_s, rd_orphan_s, rd_req_live_s, rd_dup_s, rd_alloc_s;
    logic wr_rsp_hit_s, wr_orphan_s, wr_req_live_s, wr_dup_s, wr_alloc_s;
    logic fence_orphan_s;
    logic [CNT_WIDTH-1:0] rd_age_s, wr_age_s;
    logic rd_to_s, wr_to_s;
    logic [TAG_WIDTH:0]   rd_out_next_s, wr_out_next_s;
    logic [7:0]           fence_next_s;
    logic [TAG_WIDTH-1:0] err_tag_next_s;

    // Request/response decode, checked against pre-cycle table state
    always_comb begin
        rd_req_tag_s = C0TxMdata[TAG_WIDTH-1:0];
        rd_rsp_tag_s = C0RxMdata[TAG_WIDTH-1:0];
        wr_req_tag_s = C1TxMdata[TAG_WIDTH-1:0];
        wr_rsp_tag_s = C1RxMdata[TAG_WIDTH-1:0];

        wr_req_s    = C1TxWrValid && !C1TxIsFence;
        fence_req_s = C1TxWrValid &&  C1TxIsFence;
        wr_rsp_s    = C1RxWrValid && !C1RxIsFence;
        fence_rsp_s = C1RxWrValid &&  C1RxIsFence;

        rd_rsp_hit_s  = C0RxRdValid && rd_valid_r[rd_rsp_tag_s];
        rd_orphan_s   = C0RxRdValid && !rd_valid_r[rd_rsp_tag_s];
        rd_rsp_done_s = rd_rsp_hit_s && (rd_rem_r[rd_rsp_tag_s] == 3'd1);
        // An entry completed by this cycle's response is free for a new request
        rd_req_live_s = rd_valid_r[rd_req_tag_s] &&
                        !(rd_rsp_done_s && (rd_rsp_tag_s == rd_req_tag_s));
        rd_dup_s      = C0TxRdValid && rd_req_live_s;
        rd_alloc_s    = C0TxRdValid && !rd_req_live_s;

        wr_rsp_hit_s  = wr_rsp_s && wr_valid_r[wr_rsp_tag_s];
        wr_orphan_s   = wr_rsp_s && !wr_valid_r[wr_rsp_tag_s];
        wr_req_live_s = wr_valid_r[wr_req_tag_s] &&
                        !(wr_rsp_hit_s && (wr_rsp_tag_s == wr_req_tag_s));
        wr_dup_s      = wr_req_s && wr_req_live_s;
        wr_alloc_s    = wr_req_s && !wr_req_live_s;

        // A fence response paired with a same-cycle fence request is never orphan
        fence_orphan_s = fence_rsp_s && !fence_req_s && (fence_outstanding == 8'd0);
    end

    // Timeout scanner: examine both tables at the scan pointer
    always_comb begin
        rd_age_s = timer_r - rd_time_r[scan_ptr_r];
        wr_age_s = timer_r - wr_time_r[scan_ptr_r];
        rd_to_s  = rd_valid_r[scan_ptr_r] && !rd_rep_r[scan_ptr_r] && (rd_age_s >= TIMEOUT_LIM);
        // Read wins a simultaneous timeout; the write is caught on the next pass
        wr_to_s  = wr_valid_r[scan_ptr_r] && !wr_rep_r[scan_ptr_r] && (wr_age_s >= TIMEOUT_LIM) &&
                   !rd_to_s;
    end

    // Next values for outstanding counters, fence counter and error tag
    always_comb begin
        rd_out_next_s = rd_outstanding;
        if (rd_alloc_s && !rd_rsp_done_s) begin
            rd_out_next_s = rd_outstanding + (TAG_WIDTH+1)'(1);
        end else if (!rd_alloc_s && rd_rsp_done_s) begin
            rd_out_next_s = rd_outstanding - (TAG_WIDTH+1)'(1);
        end else begin
            rd_out_next_s = rd_outstanding;
        end

        wr_out_next_s = wr_outstanding;
        if (wr_alloc_s && !wr_rsp_hit_s) begin
            wr_out_next_s = wr_outstanding + (TAG_WIDTH+1)'(1);
        end else if (!wr_alloc_s && wr_rsp_hit_s) begin
            wr_out_next_s = wr_outstanding - (TAG_WIDTH+1)'(1);
        end else begin
            wr_out_next_s = wr_outstanding;
        end

        fence_next_s = fence_outstanding;
        if (fence_req_s && !fence_rsp_s && (fence_outstanding != 8'hFF)) begin
            fence_next_s = fence_outstanding + 8'd1;
        end else if (fence_rsp_s && !fence_req_s && (fence_outstanding != 8'd0)) begin
            fence_next_s = fence_outstanding - 8'd1;
        end else begin
            fence_next_s = fence_outstanding;
        end

        // Priority: orphan > duplicate > timeout
        err_tag_next_s = err_tag;
        if (rd_orphan_s) begin
            err_tag_next_s = rd_rsp_tag_s;
        end else if (wr_orphan_s) begin
            err_tag_next_s = wr_rsp_tag_s;
        end else if (fence_orphan_s) begin
            err_tag_next_s = '0;
        end else if (rd_dup_s) begin
            err_tag_next_s = rd_req_tag_s;
        end else if (wr_dup_s) begin
            err_tag_next_s = wr_req_tag_s;
        end else if (rd_to_s || wr_to_s) begin
            err_tag_next_s = scan_ptr_r;
        end else begin
            err_tag_next_s = err_tag;
        end
    end

    // Tag table update: scanner mark, then response, then request (last wins)
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_valid_r[i] <= 1'b0;
                rd_rem_r[i]   <= 3'd0;
                rd_time_r[i]  <= '0;
                rd_rep_r[i]   <= 1'b0;
                wr_valid_r[i] <= 1'b0;
                wr_time_r[i]  <= '0;
                wr_rep_r[i]   <= 1'b0;
            end
        end else begin
            if (rd_to_s) begin
                rd_rep_r[scan_ptr_r] <= 1'b1;
            end
            if (wr_to_s) begin
                wr_rep_r[scan_ptr_r] <= 1'b1;
            end
            if (rd_rsp_hit_s) begin
                if (rd_rsp_done_s) begin
                    rd_valid_r[rd_rsp_tag_s] <= 1'b0;
                end
                rd_rem_r[rd_rsp_tag_s] <= rd_rem_r[rd_rsp_tag_s] - 3'd1;
            end
            if (wr_rsp_hit_s) begin
                wr_valid_r[wr_rsp_tag_s] <= 1'b0;
            end
            if (C0TxRdValid) begin
                rd_valid_r[rd_req_tag_s] <= 1'b1;
                rd_rem_r[rd_req_tag_s]   <= {1'b0, C0TxLen} + 3'd1;
                rd_time_r[rd_req_tag_s]  <= timer_r;
                rd_rep_r[rd_req_tag_s]   <= 1'b0;
            end
            if (wr_req_s) begin
                wr_valid_r[wr_req_tag_s] <= 1'b1;
                wr_time_r[wr_req_tag_s]  <= timer_r;
                wr_rep_r[wr_req_tag_s]   <= 1'b0;
            end
        end
    end

    // Counters, timer, scan pointer and registered error outputs
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            timer_r           <= '0;
            scan_ptr_r        <= '0;
            rd_outstanding    <= '0;
            wr_outstanding    <= '0;
            fence_outstanding <= 8'd0;
            rd_req_total      <= '0;
            wr_req_total      <= '0;
            rd_rsp_total      <= '0;
            wr_rsp_total      <= '0;
            err_dup_tag       <= 1'b0;
            err_orphan_rsp    <= 1'b0;
            err_timeout       <= 1'b0;
            err_tag           <= '0;
        end else begin
            timer_r           <= timer_r + CNT_WIDTH'(1);
            scan_ptr_r        <= scan_ptr_r + TAG_WIDTH'(1);
            rd_outstanding    <= rd_out_next_s;
            wr_outstanding    <= wr_out_next_s;
            fence_outstanding <= fence_next_s;
            rd_req_total      <= C0TxRdValid ? sat_inc(rd_req_total) : rd_req_total;
            wr_req_total      <= wr_req_s    ? sat_inc(wr_req_total) : wr_req_total;
            rd_rsp_total      <= C0RxRdValid ? sat_inc(rd_rsp_total) : rd_rsp_total;
            wr_rsp_total      <= wr_rsp_s    ? sat_inc(wr_rsp_total) : wr_rsp_total;
            err_dup_tag       <= rd_dup_s || wr_dup_s;
            err_orphan_rsp    <= rd_orphan_s || wr_orphan_s || fence_orphan_s;
            err_timeout       <= rd_to_s || wr_to_s;
            err_tag           <= err_tag_next_s;
        end
    end

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// ----------------------------------------------------------------------------
// tb_ccip_txn_tracker
// Directed self-checking bench for ccip_txn_tracker (TIMEOUT_CYCLES=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. they reflect the inputs sampled on that edge.
// ----------------------------------------------------------------------------
module tb_ccip_txn_tracker;

    logic        clk = 1'b0;
    logic        SoftReset;
    logic        C0TxRdValid;
    logic [15:0] C0TxMdata;
    logic [1:0]  C0TxLen;
    logic        C1TxWrValid;
    logic        C1TxIsFence;
    logic [15:0] C1TxMdata;
    logic        C0RxRdValid;
    logic [15:0] C0RxMdata;
    logic        C1RxWrValid;
    logic        C1RxIsFence;
    logic [15:0] C1RxMdata;
    logic [6:0]  rd_outstanding;
    logic [6:0]  wr_outstanding;
    logic [7:0]  fence_outstanding;
    logic [31:0] rd_req_total, wr_req_total, rd_rsp_total, wr_rsp_total;
    logic        err_dup_tag, err_orphan_rsp, err_timeout;
    logic [5:0]  err_tag;

    int n_cmp = 0;
    int n_bad = 0;

    ccip_txn_tracker #(
        .TAG_WIDTH      (6),
        .TIMEOUT_CYCLES (16),
        .CNT_WIDTH      (32)
    ) dut (
        .clk               (clk),
        .SoftReset         (SoftReset),
        .C0TxRdValid       (C0TxRdValid),
        .C0TxMdata         (C0TxMdata),
        .C0TxLen           (C0TxLen),
        .C1TxWrValid       (C1TxWrValid),
        .C1TxIsFence       (C1TxIsFence),
        .C1TxMdata         (C1TxMdata),
        .C0RxRdValid       (C0RxRdValid),
        .C0RxMdata         (C0RxMdata),
        .C1RxWrValid       (C1RxWrValid),
        .C1RxIsFence       (C1RxIsFence),
        .C1RxMdata         (C1RxMdata),
        .rd_outstanding    (rd_outstanding),
        .wr_outstanding    (wr_outstanding),
        .fence_outstanding (fence_outstanding),
        .rd_req_total      (rd_req_total),
        .wr_req_total      (wr_req_total),
        .rd_rsp_total      (rd_rsp_total),
        .wr_rsp_total      (wr_rsp_total),
        .err_dup_tag       (err_dup_tag),
        .err_orphan_rsp    (err_orphan_rsp),
        .err_timeout       (err_timeout),
        .err_tag           (err_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        C0TxRdValid = 1'b0; C0TxMdata = 16'h0000; C0TxLen = 2'd0;
        C1TxWrValid = 1'b0; C1TxIsFence = 1'b0; C1TxMdata = 16'h0000;
        C0RxRdValid = 1'b0; C0RxMdata = 16'h0000;
        C1RxWrValid = 1'b0; C1RxIsFence = 1'b0; C1RxMdata = 16'h0000;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        SoftReset = 1'b1;
        cycle();
        cycle();
        SoftReset = 1'b0;
    endtask

    initial begin
        int to_cnt;
        int to_first;
        logic [5:0] to_tag;

        SoftReset = 1'b0;
        do_reset();

        // Reset state
        check("rst_rd_out", 32'(rd_outstanding), 32'd0);
        check("rst_wr_out", 32'(wr_outstanding), 32'd0);
        check("rst_fence", 32'(fence_outstanding), 32'd0);
        check("rst_rd_req", rd_req_total, 32'd0);
        check("rst_errs", {29'd0, err_dup_tag, err_orphan_rsp, err_timeout}, 32'd0);
        check("rst_err_tag", 32'(err_tag), 32'd0);

        // 4-CL read, tag 5 (upper mdata bits must be ignored)
        C0TxRdValid = 1'b1; C0TxMdata = 16'hFF05; C0TxLen = 2'd3;
        cycle(); idle();
        check("rd4_out_after_req", 32'(rd_outstanding), 32'd1);
        check("rd4_req_total", rd_req_total, 32'd1);
        for (int i = 0; i < 4; i++) begin
            C0RxRdValid = 1'b1; C0RxMdata = 16'h1205;
            cycle(); idle();
            check("rd4_out_rsp", 32'(rd_outstanding), (i < 3) ? 32'd1 : 32'd0);
            check("rd4_no_orphan", 32'(err_orphan_rsp), 32'd0);
        end
        check("rd4_rsp_total", rd_rsp_total, 32'd4);
        check("rd4_no_dup", 32'(err_dup_tag), 32'd0);

        // Duplicate write tag 3
        do_reset();
        C1TxWrValid = 1'b1; C1TxMdata = 16'h0003;
        cycle(); idle();
        check("dup_first_no_err", 32'(err_dup_tag), 32'd0);
        C1TxWrValid = 1'b1; C1TxMdata = 16'h0003;
        cycle(); idle();
        check("dup_pulse", 32'(err_dup_tag), 32'd1);
        check("dup_tag", 32'(err_tag), 32'd3);
        check("dup_wr_out", 32'(wr_outstanding), 32'd1);
        check("dup_wr_req_total", wr_req_total, 32'd2);
        cycle();
        check("dup_pulse_ends", 32'(err_dup_tag), 32'd0);

        // Orphan read response tag 9
        do_reset();
        C0RxRdValid = 1'b1; C0RxMdata = 16'h0009;
        cycle(); idle();
        check("orph_pulse", 32'(err_orphan_rsp), 32'd1);
        check("orph_tag", 32'(err_tag), 32'd9);
        check("orph_rsp_total", rd_rsp_total, 32'd1);
        check("orph_rd_out", 32'(rd_outstanding), 32'd0);
        cycle();
        check("orph_pulse_ends", 32'(err_orphan_rsp), 32'd0);

        // Same cycle: duplicate read tag 10 and orphan read response tag 11
        do_reset();
        C0TxRdValid = 1'b1; C0TxMdata = 16'h000A; C0TxLen = 2'd0;
        cycle(); idle();
        C0TxRdValid = 1'b1; C0TxMdata = 16'h000A;
        C0RxRdValid = 1'b1; C0RxMdata = 16'h000B;
        cycle(); idle();
        check("prio_dup", 32'(err_dup_tag), 32'd1);
        check("prio_orphan", 32'(err_orphan_rsp), 32'd1);
        check("prio_tag", 32'(err_tag), 32'd11);

        // Timeout of read tag 2 (single CL), then late response
        do_reset();
        C0TxRdValid = 1'b1; C0TxMdata = 16'h0002; C0TxLen = 2'd0;
        cycle(); idle();
        to_cnt = 0; to_first = -1; to_tag = 6'd0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (err_timeout) begin
                to_cnt++;
                if (to_first < 0) begin
                    to_first = i;
                    to_tag = err_tag;
                end
            end
        end
        check("to_count", 32'(to_cnt), 32'd1);
        check("to_not_early", 32'(to_first >= 15), 32'd1);
        check("to_not_late", 32'(to_first >= 0 && to_first <= 79), 32'd1);
        check("to_tag", 32'(to_tag), 32'd2);
        C0RxRdValid = 1'b1; C0RxMdata = 16'h0002;
        cycle(); idle();
        check("to_late_rsp_clears", 32'(rd_outstanding), 32'd0);
        check("to_late_rsp_no_orphan", 32'(err_orphan_rsp), 32'd0);

        // Write tag 7 completes and re-allocates in one cycle
        do_reset();
        C1TxWrValid = 1'b1; C1TxMdata = 16'h0007;
        cycle(); idle();
        cycle(); cycle();
        C1TxWrValid = 1'b1; C1TxMdata = 16'h0007;
        C1RxWrValid = 1'b1; C1RxMdata = 16'h0007;
        cycle(); idle();
        check("wr7_no_dup", 32'(err_dup_tag), 32'd0);
        check("wr7_no_orphan", 32'(err_orphan_rsp), 32'd0);
        check("wr7_out", 32'(wr_outstanding), 32'd1);
        check("wr7_rsp_total", wr_rsp_total, 32'd1);

        // Orphan write response with same-cycle request still allocates
        do_reset();
        C1TxWrValid = 1'b1; C1TxMdata = 16'h0004;
        C1RxWrValid = 1'b1; C1RxMdata = 16'h0004;
        cycle(); idle();
        check("wr4_orphan", 32'(err_orphan_rsp), 32'd1);
        check("wr4_no_dup", 32'(err_dup_tag), 32'd0);
        check("wr4_tag", 32'(err_tag), 32'd4);
        check("wr4_out", 32'(wr_outstanding), 32'd1);

        // Fences, mid-run reset, orphan fence response
        do_reset();
        C1TxWrValid = 1'b1; C1TxIsFence = 1'b1;
        cycle(); cycle(); idle();
        check("fence_two", 32'(fence_outstanding), 32'd2);
        check("fence_no_wr_entry", 32'(wr_outstanding), 32'd0);
        C1TxWrValid = 1'b1; C1TxIsFence = 1'b1;
        C1RxWrValid = 1'b1; C1RxIsFence = 1'b1;
        cycle(); idle();
        check("fence_net_zero", 32'(fence_outstanding), 32'd2);
        check("fence_net_no_err", 32'(err_orphan_rsp), 32'd0);
        C1RxWrValid = 1'b1; C1RxIsFence = 1'b1;
        cycle(); idle();
        check("fence_dec", 32'(fence_outstanding), 32'd1);
        C0TxRdValid = 1'b1; C0TxMdata = 16'h0001;
        cycle(); idle();
        check("mid_rd_out", 32'(rd_outstanding), 32'd1);
        SoftReset = 1'b1;
        C0TxRdValid = 1'b1; C0TxMdata = 16'h0006;
        C1TxWrValid = 1'b1; C1TxIsFence = 1'b1;
        cycle();
        SoftReset = 1'b0; idle();
        check("srst_fence", 32'(fence_outstanding), 32'd0);
        check("srst_rd_out", 32'(rd_outstanding), 32'd0);
        check("srst_rd_req", rd_req_total, 32'd0);
        check("srst_wr_rsp", wr_rsp_total, 32'd0);
        C1RxWrValid = 1'b1; C1RxIsFence = 1'b1;
        cycle(); idle();
        check("fence_orphan", 32'(err_orphan_rsp), 32'd1);
        check("fence_orphan_tag", 32'(err_tag), 32'd0);
        check("fence_stays_zero", 32'(fence_outstanding), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccip_txn_tracker.md
# ccip_txn_tracker

Passive CCI-P transaction tracker that taps the same AFU-side channel signals the transaction logger observes. It matches AFU memory read and write requests against their responses by mdata tag and keeps outstanding counts. It also flags protocol violations: duplicate tag, orphan response and response timeout. Its outputs feed the ASE end-of-simulation statistics and raise error pulses that the testbench routes to the logger's buffer-message injection.

## Interface
Parameters:
- TAG_WIDTH, 6: low mdata bits used as table index; table depth 2^TAG_WIDTH per direction.
- TIMEOUT_CYCLES, 4096: request age at which a timeout is reported.
- CNT_WIDTH, 32: width of cumulative counters and the internal cycle timer.

Ports:
- clk  in  1  clock.
- SoftReset  in  1  synchronous, active-high reset.
- C0TxRdValid  in  1  read request valid.
- C0TxMdata  in  16  read request mdata.
- C0TxLen  in  2  read length; 0..3 means 1..4 CL.
- C1TxWrValid  in  1  write or fence request valid.
- C1TxIsFence  in  1  the C1 request is a WrFence.
- C1TxMdata  in  16  write request mdata.
- C0RxRdValid  in  1  read response valid; atomic responses are excluded by the wrapper.
- C0RxMdata  in  16  read response mdata.
- C1RxWrValid  in  1  write or fence response valid.
- C1RxIsFence  in  1  the C1 response is a WrFenceRsp.
- C1RxMdata  in  16  write response mdata.
- rd_outstanding  out  TAG_WIDTH+1  valid read table entries.
- wr_outstanding  out  TAG_WIDTH+1  valid write table entries.
- fence_outstanding  out  8  fences issued but not yet responded.
- rd_req_total, wr_req_total, rd_rsp_total, wr_rsp_total  out  CNT_WIDTH each  cumulative counts, saturating.
- err_dup_tag  out  1  one-cycle pulse.
- err_orphan_rsp  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.
- err_tag  out  TAG_WIDTH  tag of the most recent error; held until the next error.

## Operation
- Read table entry fields: valid, remaining[2:0], issue_time[CNT_WIDTH-1:0], reported. The write table has the same fields; remaining is unused there.
- Tag is mdata[TAG_WIDTH-1:0]. Upper mdata bits are ignored.
- Read request: set valid=1, remaining=C0TxLen+1, issue_time=timer, reported=0. If the entry was already valid, also pulse err_dup_tag and overwrite the entry.
- Read response: if the entry is invalid, pulse err_orphan_rsp and change no state. Otherwise decrement remaining; when remaining reaches 0, clear valid. Each CL response counts once in rd_rsp_total.
- Write request (C1TxIsFence=0): same as a read request with remaining=1.
- Write response (C1RxIsFence=0): orphan check as for reads; a matching response clears valid.
- Fence request: increment fence_outstanding. Fence response: decrement it. A fence response while fence_outstanding==0 pulses err_orphan_rsp with err_tag=0. Fences use no table entries.
- Timeout scanner: a TAG_WIDTH-bit pointer advances by 1 every cycle and wraps. It checks the read and write entries at the pointer. If valid && !reported && (timer - issue_time) mod 2^CNT_WIDTH >= TIMEOUT_CYCLES, it pulses err_timeout and sets reported=1. When both tables time out in the same cycle, read has priority for err_tag and the write entry is reported on the next pass.
- timer is a free-running CNT_WIDTH counter that wraps; age is computed with modular subtraction.
- Counters saturate at all-ones and do not wrap.

## Timing
- All outputs are registered. Effects appear on the cycle after the input sample edge, and error pulses last exactly one cycle.
- Same cycle, same tag, request and response in one direction: the response is checked against pre-cycle state first, then the request allocates. If the response completes the old entry, no err_dup_tag. If the entry was invalid, err_orphan_rsp pulses and the new request still allocates.
- Same-cycle fence request and response: net zero change, no error.
- Several error types in the same cycle pulse independently. err_tag priority is orphan > dup > timeout.
- SoftReset, including mid-operation: all entries invalid, all counters, timer and scan pointer at 0, fence_outstanding=0, err_* pulses=0, err_tag=0. Inputs are ignored in reset cycles.
- rd_outstanding and wr_outstanding equal the population of valid bits, kept as incremental counters.

## Test plan
- Read of 4 CL, tag 5, then 4 responses tag 5 -> rd_outstanding goes 1 then 0 after the 4th; rd_rsp_total=4; no errors.
- Write tag 3 issued twice with no response -> err_dup_tag pulses one cycle after the 2nd request; err_tag=3; wr_outstanding=1.
- Read response tag 9 with an empty table -> err_orphan_rsp pulse; err_tag=9; rd_rsp_total=1; rd_outstanding=0.
- TIMEOUT_CYCLES=16, read tag 2 and no response -> err_timeout within 16+64 cycles, exactly once; err_tag=2; a late response still clears the entry.
- Write tag 7 outstanding, then write response tag 7 and new write tag 7 in the same cycle -> no errors; wr_outstanding=1 with the new issue_time.
- Two fences, then SoftReset asserted mid-run -> fence_outstanding=0 and all counters 0. A fence response after reset pulses err_orphan_rsp.
